// File: rtl/memory_stage_ctrl_if.sv
// Execute/writeback-side stage signals plus the data-memory request/response bus.
// The slave modport is the memory stage; the master modport is its environment.
interface memory_stage_ctrl_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        opcode;
  logic [DATA_W-1:0] valA;
  logic [ADDR_W-1:0] valE;
  logic [DATA_W-1:0] valP;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              m_valid;
  logic [DATA_W-1:0] valM;
  logic              dmem_error;

  modport slave (
    input  in_valid, opcode, valA, valE, valP, mem_ready, mem_rvalid, mem_rdata,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata, m_valid, valM, dmem_error
  );

  modport master (
    output in_valid, opcode, valA, valE, valP, mem_ready, mem_rvalid, mem_rdata,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, m_valid, valM, dmem_error
  );
endinterface

// File: rtl/memory_stage_ctrl.sv
// Y86 memory stage: decodes icode into a data-memory read/write, runs a request/response
// handshake with range checking and a timeout, and reports one completion pulse per op.
module memory_stage_ctrl #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 64,
  parameter int MEM_BYTES = 4096,
  parameter int TIMEOUT   = 255
) (
  input logic                clk,
  input logic                reset,
  memory_stage_ctrl_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]   TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(MEM_BYTES);
  localparam logic [ADDR_W:0] SPAN  = (ADDR_W + 1)'(BYTES);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] valm_q, valm_d;
  logic              err_q, err_d;

  logic [3:0]        icode;
  logic              isWrite, isRead, rangeErr, timedOut;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqData;
  logic [ADDR_W:0]   addrEnd;

  // The end address is formed one bit wider so an address near the top of the space cannot wrap into range.
  always_comb begin
    icode    = bus.opcode[7:4];
    isWrite  = (icode == 4'h4) || (icode == 4'hA) || (icode == 4'h8);
    isRead   = (icode == 4'h5) || (icode == 4'h9) || (icode == 4'hB);
    reqAddr  = ((icode == 4'h9) || (icode == 4'hB)) ? ADDR_W'(bus.valA) : bus.valE;
    reqData  = (icode == 4'h8) ? bus.valP : bus.valA;
    addrEnd  = {1'b0, reqAddr} + SPAN;
    rangeErr = (isWrite || isRead) && (addrEnd > LIMIT);
    timedOut = (TIMEOUT != 0) && (timer_q == TLAST);
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    mem_req_d = mem_req_q;
    mem_we_d  = mem_we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    m_valid_d = 1'b0;
    valm_d    = valm_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          timer_d = '0;
          err_d   = rangeErr;
          if (!(isWrite || isRead) || rangeErr) begin
            state_d   = DONE;
            m_valid_d = 1'b1;
            valm_d    = '0;
          end else begin
            state_d   = REQ;
            mem_req_d = 1'b1;
            mem_we_d  = isWrite;
            addr_d    = reqAddr;
            wdata_d   = isWrite ? reqData : '0;
          end
        end
      end
      // An accept in the timeout cycle still counts as progress.
      REQ: begin
        timer_d = timer_q + 1'b1;
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            state_d   = DONE;
            m_valid_d = 1'b1;
            valm_d    = '0;
          end else begin
            state_d = WAIT;
          end
        end else if (timedOut) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          m_valid_d = 1'b1;
          valm_d    = '0;
          err_d     = 1'b1;
        end
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (bus.mem_rvalid) begin
          state_d   = DONE;
          m_valid_d = 1'b1;
          valm_d    = bus.mem_rdata;
        end else if (timedOut) begin
          state_d   = DONE;
          m_valid_d = 1'b1;
          valm_d    = '0;
          err_d     = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      m_valid_q <= 1'b0;
      valm_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      m_valid_q <= m_valid_d;
      valm_q    <= valm_d;
      err_q     <= err_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.valM       = valm_q;
  assign bus.dmem_error = err_q;
endmodule

// File: tb/tb_memory_stage_ctrl.sv
// Scoreboard bench for memory_stage_ctrl: a long-timeout instance for the handshake cases
// and a TIMEOUT=4 instance for the read/timeout cases.
module tb_memory_stage_ctrl;
  localparam int DW = 64;
  localparam int AW = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  memory_stage_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  memory_stage_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) busT ();

  memory_stage_ctrl #(.DATA_W(DW), .ADDR_W(AW), .MEM_BYTES(4096), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  memory_stage_ctrl #(.DATA_W(DW), .ADDR_W(AW), .MEM_BYTES(4096), .TIMEOUT(4)) dutT (
    .clk(clk), .reset(reset), .bus(busT.slave));

  typedef struct {
    logic [63:0] valM;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t expQ[$];
  exp_t expQT[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cycleCnt = 0;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issue one op for a single cycle; lat>0 queues the completion expected lat cycles later.
  task automatic applyStimulus(input bit sel, input logic [7:0] op, input logic [63:0] a, e, p, expV,
                               input logic expE, input int lat);
    exp_t x;
    @(negedge clk);
    if (!sel) begin
      checkOutput("main_in_ready", {63'd0, bus.in_ready}, 64'd1);
      bus.in_valid = 1'b1; bus.opcode = op; bus.valA = a; bus.valE = e; bus.valP = p;
    end else begin
      checkOutput("t_in_ready", {63'd0, busT.in_ready}, 64'd1);
      busT.in_valid = 1'b1; busT.opcode = op; busT.valA = a; busT.valE = e; busT.valP = p;
    end
    if (lat > 0) begin
      x.valM = expV; x.err = expE; x.cyc = cycleCnt + lat;
      if (!sel) expQ.push_back(x);
      else expQT.push_back(x);
    end
    @(negedge clk);
    if (!sel) bus.in_valid = 1'b0;
    else busT.in_valid = 1'b0;
  endtask

  // Monitor: every completion pulse pops the oldest expectation for that instance.
  always @(negedge clk) begin
    exp_t e;
    if (bus.m_valid === 1'b1) begin
      if (expQ.size() == 0) checkOutput("main_unexpected_m_valid", 64'd1, 64'd0);
      else begin
        e = expQ.pop_front();
        checkOutput("main_done_cycle", 64'(cycleCnt), 64'(e.cyc));
        checkOutput("main_valM", bus.valM, e.valM);
        checkOutput("main_dmem_error", {63'd0, bus.dmem_error}, {63'd0, e.err});
      end
    end
    if (busT.m_valid === 1'b1) begin
      if (expQT.size() == 0) checkOutput("t_unexpected_m_valid", 64'd1, 64'd0);
      else begin
        e = expQT.pop_front();
        checkOutput("t_done_cycle", 64'(cycleCnt), 64'(e.cyc));
        checkOutput("t_valM", busT.valM, e.valM);
        checkOutput("t_dmem_error", {63'd0, busT.dmem_error}, {63'd0, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.in_valid = 0; bus.opcode = 0; bus.valA = 0; bus.valE = 0; bus.valP = 0;
    bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    busT.in_valid = 0; busT.opcode = 0; busT.valA = 0; busT.valE = 0; busT.valP = 0;
    busT.mem_ready = 0; busT.mem_rvalid = 0; busT.mem_rdata = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state and stray memory inputs while idle
    checkOutput("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    checkOutput("rst_mem_req", {63'd0, bus.mem_req}, 64'd0);
    checkOutput("rst_mem_we", {63'd0, bus.mem_we}, 64'd0);
    checkOutput("rst_mem_addr", bus.mem_addr, 64'd0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 64'd0);
    checkOutput("rst_m_valid", {63'd0, bus.m_valid}, 64'd0);
    checkOutput("rst_valM", bus.valM, 64'd0);
    checkOutput("rst_dmem_error", {63'd0, bus.dmem_error}, 64'd0);
    checkOutput("rst_t_mem_req", {63'd0, busT.mem_req}, 64'd0);
    bus.mem_rvalid = 1; bus.mem_ready = 1; bus.mem_rdata = 64'hBAD;
    repeat (2) @(negedge clk);
    checkOutput("stray_m_valid", {63'd0, bus.m_valid}, 64'd0);
    checkOutput("stray_mem_req", {63'd0, bus.mem_req}, 64'd0);
    bus.mem_rvalid = 0;

    // rmmovq write, memory ready immediately
    applyStimulus(0, 8'h40, 64'hDEAD, 64'h100, 64'h0, 64'h0, 1'b0, 2);
    checkOutput("wr_mem_req", {63'd0, bus.mem_req}, 64'd1);
    checkOutput("wr_mem_we", {63'd0, bus.mem_we}, 64'd1);
    checkOutput("wr_mem_addr", bus.mem_addr, 64'h100);
    checkOutput("wr_mem_wdata", bus.mem_wdata, 64'hDEAD);
    checkOutput("wr_in_ready", {63'd0, bus.in_ready}, 64'd0);
    @(negedge clk);
    checkOutput("wr_req_dropped", {63'd0, bus.mem_req}, 64'd0);
    bus.mem_ready = 0;

    // mrmovq read with 3 stalled cycles; rvalid in the accept cycle must be ignored
    applyStimulus(0, 8'h50, 64'h0, 64'h20, 64'h0, 64'h1234, 1'b0, 6);
    for (int k = 0; k < 3; k++) begin
      checkOutput("rd_mem_req", {63'd0, bus.mem_req}, 64'd1);
      checkOutput("rd_mem_we", {63'd0, bus.mem_we}, 64'd0);
      checkOutput("rd_mem_addr", bus.mem_addr, 64'h20);
      if (k == 2) begin
        bus.mem_ready = 1; bus.mem_rvalid = 1; bus.mem_rdata = 64'hBAD;
      end
      @(negedge clk);
    end
    bus.mem_ready = 0; bus.mem_rvalid = 0;
    checkOutput("rd_req_dropped", {63'd0, bus.mem_req}, 64'd0);
    @(negedge clk);
    bus.mem_rvalid = 1; bus.mem_rdata = 64'h1234;
    @(negedge clk);
    bus.mem_rvalid = 0;

    // ret reads from valA, not valE
    bus.mem_ready = 1;
    applyStimulus(0, 8'h90, 64'h200, 64'h999, 64'h0, 64'h77, 1'b0, 3);
    checkOutput("ret_mem_addr", bus.mem_addr, 64'h200);
    checkOutput("ret_mem_we", {63'd0, bus.mem_we}, 64'd0);
    @(negedge clk);
    bus.mem_ready = 0; bus.mem_rvalid = 1; bus.mem_rdata = 64'h77;
    @(negedge clk);
    bus.mem_rvalid = 0;

    // call at the last legal word, then two out-of-range addresses
    bus.mem_ready = 1;
    applyStimulus(0, 8'h80, 64'h0, 64'hFF8, 64'h55, 64'h0, 1'b0, 2);
    checkOutput("call_mem_req", {63'd0, bus.mem_req}, 64'd1);
    checkOutput("call_mem_we", {63'd0, bus.mem_we}, 64'd1);
    checkOutput("call_mem_addr", bus.mem_addr, 64'hFF8);
    checkOutput("call_mem_wdata", bus.mem_wdata, 64'h55);
    @(negedge clk);
    applyStimulus(0, 8'h80, 64'h0, 64'hFFC, 64'h55, 64'h0, 1'b1, 1);
    checkOutput("range_no_req", {63'd0, bus.mem_req}, 64'd0);
    applyStimulus(0, 8'h80, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h55, 64'h0, 1'b1, 1);
    checkOutput("wrap_no_req", {63'd0, bus.mem_req}, 64'd0);

    // OPq: no memory access, error cleared
    applyStimulus(0, 8'h60, 64'h1, 64'h2, 64'h3, 64'h0, 1'b0, 1);
    checkOutput("opq_no_req", {63'd0, bus.mem_req}, 64'd0);
    bus.mem_ready = 0;

    // Short-timeout instance: 1-cycle memory read, then popq that is never accepted
    busT.mem_ready = 1;
    applyStimulus(1, 8'h50, 64'h0, 64'h8, 64'h0, 64'hCAFE, 1'b0, 3);
    checkOutput("t_rd_mem_req", {63'd0, busT.mem_req}, 64'd1);
    checkOutput("t_rd_mem_addr", busT.mem_addr, 64'h8);
    @(negedge clk);
    busT.mem_ready = 0; busT.mem_rvalid = 1; busT.mem_rdata = 64'hCAFE;
    @(negedge clk);
    busT.mem_rvalid = 0;
    applyStimulus(1, 8'hB0, 64'h40, 64'h0, 64'h0, 64'h0, 1'b1, 5);
    for (int k = 0; k < 4; k++) begin
      checkOutput("to_mem_req", {63'd0, busT.mem_req}, 64'd1);
      checkOutput("to_mem_addr", busT.mem_addr, 64'h40);
      @(negedge clk);
    end
    checkOutput("to_req_dropped", {63'd0, busT.mem_req}, 64'd0);
    @(negedge clk);

    // Reset while waiting for read data; late rvalid must not complete anything
    bus.mem_ready = 1;
    applyStimulus(0, 8'h50, 64'h0, 64'h30, 64'h0, 64'h0, 1'b0, 0);
    @(negedge clk);
    bus.mem_ready = 0;
    checkOutput("wait_in_ready", {63'd0, bus.in_ready}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst_mem_req", {63'd0, bus.mem_req}, 64'd0);
    checkOutput("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    checkOutput("midrst_m_valid", {63'd0, bus.m_valid}, 64'd0);
    checkOutput("midrst_valM", bus.valM, 64'd0);
    bus.mem_rvalid = 1; bus.mem_rdata = 64'hEEEE;
    @(negedge clk);
    bus.mem_rvalid = 0;
    checkOutput("late_rvalid_m_valid", {63'd0, bus.m_valid}, 64'd0);
    applyStimulus(0, 8'h10, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1);
    checkOutput("nop_no_req", {63'd0, bus.mem_req}, 64'd0);

    repeat (2) @(negedge clk);
    for (int k = 0; k < 20 && (expQ.size() != 0 || expQT.size() != 0); k++) @(negedge clk);
    checkOutput("pending_main", 64'(expQ.size()), 64'd0);
    checkOutput("pending_t", 64'(expQT.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
